// File: rtl/sdram_rom_loader.sv
`default_nettype none
// ============================================================================
// Module : sdram_rom_loader
// Packs the byte-serial ROM download into masked 16-bit words, buffers them,
// and writes them through the SDRAM controller's toggle req/ack port.
// Rev    : 1.0
// ============================================================================
module sdram_rom_loader #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [22:0] ADDR_OFFSET = 23'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [23:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        dl_ready,
   output logic        mem_req,
   input  logic        mem_ack,
   output logic        mem_we,
   output logic [22:0] mem_a,
   output logic [1:0]  mem_ds,
   output logic [15:0] mem_d,
   output logic        busy,
   output logic        done
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_READY_MAX = c_CNT_W'(FIFO_DEPTH - 2);

   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } word_t;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   word_t               part_q, part_d;
   logic                part_valid_q, part_valid_d;
   word_t               fifo_q [FIFO_DEPTH];
   word_t               fifo_d [FIFO_DEPTH];
   logic [c_PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_CNT_W-1:0]  count_q, count_d;
   state_t              state_q, state_d;
   logic                mem_req_q, mem_req_d;
   logic [22:0]         mem_a_q, mem_a_d;
   logic [1:0]          mem_ds_q, mem_ds_d;
   logic [15:0]         mem_d_q, mem_d_d;
   logic                active_q, active_d;
   logic                drain_q, drain_d;
   logic                done_q, done_d;

   logic [22:0]         w_byte_waddr;
   logic                w_byte_lane;
   logic                w_accept;
   logic                w_fall;
   logic                w_conflict;
   logic                w_push;
   logic                w_pop;
   logic                w_busy;
   word_t               w_head;

   assign dl_ready = ~reset & (count_q <= c_READY_MAX);
   assign w_head   = fifo_q[rd_ptr_q];
   assign w_busy   = part_valid_q | (count_q != '0) | (state_q == WAIT_ACK);

   // Packing register: at most one FIFO push per cycle, so the ready margin
   // of two free entries always covers a flush and a completed word.
   always_comb begin
      w_byte_waddr = dl_addr[23:1] + ADDR_OFFSET;
      w_byte_lane  = dl_addr[0];
      w_accept     = dl_wr & dl_ready;
      w_fall       = active_q & ~dl_active;
      w_conflict   = (part_q.a != w_byte_waddr) |
                     (w_byte_lane ? part_q.ds[1] : part_q.ds[0]);
      w_push       = part_valid_q & ((part_q.ds == 2'b11) | w_fall |
                                     (w_accept & w_conflict));

      part_d       = part_q;
      part_valid_d = part_valid_q;
      if (w_push) begin
         part_valid_d = 1'b0;
      end
      if (w_accept) begin
         if (w_push | ~part_valid_q) begin
            part_d.a     = w_byte_waddr;
            part_d.ds    = 2'b00;
            part_d.d     = 16'h0000;
            part_valid_d = 1'b1;
         end
         if (w_byte_lane) begin
            part_d.ds[1]   = 1'b1;
            part_d.d[15:8] = dl_data;
         end else begin
            part_d.ds[0]   = 1'b1;
            part_d.d[7:0]  = dl_data;
         end
      end
   end

   // Issue FSM: one outstanding toggle request at a time.
   always_comb begin
      state_d   = state_q;
      mem_req_d = mem_req_q;
      mem_a_d   = mem_a_q;
      mem_ds_d  = mem_ds_q;
      mem_d_d   = mem_d_q;
      w_pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((mem_req_q == mem_ack) && (count_q != '0)) begin
               mem_a_d   = w_head.a;
               mem_ds_d  = w_head.ds;
               mem_d_d   = w_head.d;
               mem_req_d = ~mem_req_q;
               state_d   = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (mem_ack == mem_req_q) begin
               w_pop   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_d = fifo_q;
      if (w_push) begin
         fifo_d[wr_ptr_q] = part_q;
      end
      wr_ptr_d = w_push ? wr_ptr_q + c_PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = w_pop  ? rd_ptr_q + c_PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (w_push & ~w_pop) begin
         count_d = count_q + c_CNT_W'(1);
      end else if (~w_push & w_pop) begin
         count_d = count_q - c_CNT_W'(1);
      end
   end

   // A new falling edge while done fires keeps the drain armed for that download.
   always_comb begin
      active_d = dl_active;
      done_d   = drain_q & ~w_busy;
      drain_d  = w_fall | (drain_q & ~done_d);
   end

   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         part_q       <= '0;
         part_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= IDLE;
         mem_req_q    <= mem_ack;
         mem_a_q      <= '0;
         mem_ds_q     <= '0;
         mem_d_q      <= '0;
         active_q     <= 1'b0;
         drain_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         part_q       <= part_d;
         part_valid_q <= part_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_a_q      <= mem_a_d;
         mem_ds_q     <= mem_ds_d;
         mem_d_q      <= mem_d_d;
         active_q     <= active_d;
         drain_q      <= drain_d;
         done_q       <= done_d;
      end
   end

   assign mem_req = mem_req_q;
   assign mem_we  = 1'b1;
   assign mem_a   = mem_a_q;
   assign mem_ds  = mem_ds_q;
   assign mem_d   = mem_d_q;
   assign busy    = w_busy;
   assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_rom_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_rom_loader
// Table-driven downloads and hand sequences, checked by a scoreboard against
// a delayed-acknowledge SDRAM port model.
// Rev    : 1.0
// ============================================================================
module tb_sdram_rom_loader;

   localparam logic [22:0] c_OFFSET = 23'h080000;
   localparam int          c_DEPTH  = 4;

   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } word_t;

   typedef struct packed {
      logic [1:0]        n;
      logic [1:0][23:0]  a;
      logic [1:0][7:0]   b;
      logic [1:0]        nw;
      word_t [1:0]       w;
   } vec_t;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        dl_active = 1'b0;
   logic        dl_wr     = 1'b0;
   logic [23:0] dl_addr   = '0;
   logic [7:0]  dl_data   = '0;
   logic        mem_ack   = 1'b0;
   logic        dl_ready, mem_req, mem_we, busy, done;
   logic [22:0] mem_a;
   logic [1:0]  mem_ds;
   logic [15:0] mem_d;

   int    checks    = 0;
   int    errors    = 0;
   int    ack_delay = 10;
   bit    ack_hold  = 1'b0;
   bit    saw_stall = 1'b0;
   word_t sb[$];

   bit          pv  = 1'b0;
   logic [22:0] pa  = '0;
   logic [1:0]  pds = '0;
   logic [15:0] pd  = '0;

   vec_t vt [7];

   sdram_rom_loader #(
      .FIFO_DEPTH  (c_DEPTH),
      .ADDR_OFFSET (c_OFFSET)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .dl_active (dl_active),
      .dl_wr     (dl_wr),
      .dl_addr   (dl_addr),
      .dl_data   (dl_data),
      .dl_ready  (dl_ready),
      .mem_req   (mem_req),
      .mem_ack   (mem_ack),
      .mem_we    (mem_we),
      .mem_a     (mem_a),
      .mem_ds    (mem_ds),
      .mem_d     (mem_d),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lanes(input logic [15:0] d, input logic [1:0] ds);
      return d & {{8{ds[1]}}, {8{ds[0]}}};
   endfunction

   function automatic word_t wd(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
      word_t w;
      w.a = a; w.ds = ds; w.d = d;
      return w;
   endfunction

   function automatic vec_t mk(input int n, input logic [23:0] a0, input logic [7:0] b0,
                               input logic [23:0] a1, input logic [7:0] b1,
                               input int nw, input word_t w0, input word_t w1);
      vec_t v;
      v.n = 2'(n); v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
      v.nw = 2'(nw); v.w[0] = w0; v.w[1] = w1;
      return v;
   endfunction

   // Reference packing for the hand sequences, written from the lane rules.
   task automatic model_byte(input logic [23:0] a, input logic [7:0] b);
      logic [22:0] wa;
      wa = a[23:1] + c_OFFSET;
      if (pv && (wa != pa || pds[a[0]])) begin
         sb.push_back(wd(pa, pds, pd));
         pv = 1'b0;
      end
      if (!pv) begin
         pv = 1'b1; pa = wa; pds = 2'b00; pd = 16'h0;
      end
      pds[a[0]] = 1'b1;
      if (a[0]) pd[15:8] = b;
      else      pd[7:0]  = b;
      if (pds == 2'b11) begin
         sb.push_back(wd(pa, pds, pd));
         pv = 1'b0;
      end
   endtask

   // SDRAM port: captures and scores each new request, checks the request
   // fields stay put, then toggles the ack after ack_delay cycles.
   initial begin : responder
      bit    in_wait;
      bit    stable_ok;
      int    cnt;
      word_t cur;
      word_t e;
      in_wait = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_wait = 1'b0;
         end else if (!in_wait) begin
            if (mem_req != mem_ack) begin
               in_wait = 1'b1; cnt = 0; stable_ok = 1'b1;
               cur = wd(mem_a, mem_ds, mem_d);
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_write actual a=%0h ds=%0b d=%0h required none", mem_a, mem_ds, mem_d);
               end else begin
                  e = sb.pop_front();
                  check("mem_a", 32'(mem_a), 32'(e.a));
                  check("mem_ds", 32'(mem_ds), 32'(e.ds));
                  check("mem_d_lanes", 32'(lanes(mem_d, e.ds)), 32'(lanes(e.d, e.ds)));
                  check("mem_we", 32'(mem_we), 32'h1);
               end
            end
         end else if (mem_req == mem_ack) begin
            in_wait = 1'b0;
         end else begin
            if (wd(mem_a, mem_ds, mem_d) != cur) stable_ok = 1'b0;
            if (!ack_hold) cnt++;
            if (cnt >= ack_delay) begin
               check("req_fields_stable", 32'(stable_ok), 32'h1);
               mem_ack = ~mem_ack;
               in_wait = 1'b0;
            end
         end
      end
   end

   task automatic send_byte(input logic [23:0] a, input logic [7:0] b, input bit use_model);
      int n;
      n = 0;
      @(negedge clk);
      while (!dl_ready && n < 400) begin
         n++;
         @(negedge clk);
      end
      if (n > 0) saw_stall = 1'b1;
      if (!dl_ready) begin
         checks++; errors++;
         $display("FAIL dl_ready_timeout actual=0 required=1");
      end else begin
         dl_wr = 1'b1; dl_addr = a; dl_data = b;
         if (use_model) model_byte(a, b);
         @(posedge clk);
         #1 dl_wr = 1'b0;
      end
   endtask

   task automatic end_download(input bit use_model);
      int n;
      @(negedge clk);
      dl_active = 1'b0;
      if (use_model && pv) begin
         sb.push_back(wd(pa, pds, pd));
         pv = 1'b0;
      end
      n = 0;
      while (!done && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 32'h1);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'h0);
      check("busy_after_done", 32'(busy), 32'h0);
      check("all_words_written", 32'(sb.size()), 32'h0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      vt[0] = mk(2, 24'h000000, 8'h11, 24'h000001, 8'h22, 1,
                 wd(23'h080000, 2'b11, 16'h2211), wd(23'h0, 2'b00, 16'h0));
      vt[1] = mk(1, 24'h000005, 8'hAB, 24'h0, 8'h0, 1,
                 wd(23'h080002, 2'b10, 16'hAB00), wd(23'h0, 2'b00, 16'h0));
      vt[2] = mk(2, 24'h000010, 8'h01, 24'h000020, 8'h02, 2,
                 wd(23'h080008, 2'b01, 16'h0001), wd(23'h080010, 2'b01, 16'h0002));
      vt[3] = mk(2, 24'hFFFFFE, 8'h5A, 24'hFFFFFF, 8'hA5, 1,
                 wd(23'h07FFFF, 2'b11, 16'hA55A), wd(23'h0, 2'b00, 16'h0));
      vt[4] = mk(2, 24'h000004, 8'h33, 24'h000004, 8'h44, 2,
                 wd(23'h080002, 2'b01, 16'h0033), wd(23'h080002, 2'b01, 16'h0044));
      vt[5] = mk(2, 24'h000007, 8'h66, 24'h000006, 8'h77, 1,
                 wd(23'h080003, 2'b11, 16'h6677), wd(23'h0, 2'b00, 16'h0));
      vt[6] = mk(0, 24'h0, 8'h0, 24'h0, 8'h0, 0,
                 wd(23'h0, 2'b00, 16'h0), wd(23'h0, 2'b00, 16'h0));

      repeat (3) @(negedge clk);
      check("ready_in_reset", 32'(dl_ready), 32'h0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mem_req_eq_ack", 32'(mem_req), 32'(mem_ack));
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_mem_a", 32'(mem_a), 32'h0);
      check("rst_mem_ds", 32'(mem_ds), 32'h0);
      check("rst_mem_d", 32'(mem_d), 32'h0);
      check("rst_dl_ready", 32'(dl_ready), 32'h1);

      // Table of short downloads with literal expected words.
      ack_delay = 10;
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < int'(vt[i].nw); k++) sb.push_back(vt[i].w[k]);
         @(negedge clk);
         dl_active = 1'b1;
         for (int k = 0; k < int'(vt[i].n); k++) send_byte(vt[i].a[k], vt[i].b[k], 1'b0);
         end_download(1'b0);
      end

      // Eight consecutive bytes from 0x10 with a long ack.
      ack_delay = 12;
      @(negedge clk);
      dl_active = 1'b1;
      for (int k = 0; k < 8; k++) send_byte(24'h000010 + 24'(k), 8'(8'h30 + k), 1'b1);
      end_download(1'b1);

      // Withheld ack while the stream runs continuously.
      ack_delay = 3;
      ack_hold  = 1'b1;
      saw_stall = 1'b0;
      fork
         begin
            repeat (200) @(posedge clk);
            ack_hold = 1'b0;
         end
      join_none
      @(negedge clk);
      dl_active = 1'b1;
      for (int k = 0; k < 40; k++) send_byte(24'h000100 + 24'(k), 8'($urandom_range(0, 255)), 1'b1);
      check("ready_dropped_under_backpressure", 32'(saw_stall), 32'h1);
      end_download(1'b1);

      // Reset while a request is outstanding with mem_ack = 1, mem_req = 0.
      ack_delay = 4;
      ack_hold  = 1'b1;
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         dl_active = 1'b1;
         send_byte(24'h000040, 8'h5C, 1'b1);
         send_byte(24'h000041, 8'hC5, 1'b1);
         n = 0;
         while (mem_req == mem_ack && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (mem_ack == 1'b1) break;
         ack_hold = 1'b0;
         end_download(1'b1);
         ack_hold = 1'b1;
      end
      check("pre_reset_ack", 32'(mem_ack), 32'h1);
      check("pre_reset_req", 32'(mem_req), 32'h0);
      @(negedge clk);
      reset     = 1'b1;
      dl_active = 1'b0;
      repeat (2) @(negedge clk);
      check("ready_in_mid_reset", 32'(dl_ready), 32'h0);
      sb.delete();
      pv       = 1'b0;
      reset    = 1'b0;
      ack_hold = 1'b0;
      @(negedge clk);
      check("post_reset_req", 32'(mem_req), 32'h1);
      check("post_reset_busy", 32'(busy), 32'h0);
      repeat (20) @(negedge clk);
      check("no_spurious_req", 32'(mem_req), 32'h1);
      check("no_done_after_reset", 32'(done), 32'h0);
      @(negedge clk);
      dl_active = 1'b1;
      send_byte(24'h000200, 8'hC3, 1'b1);
      end_download(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
